// File: rtl/fb_sdram_arbiter.sv
// fb_sdram_arbiter: schedules the single SDRAM command port among refresh,
// VGA read and camera write requesters, and generates ping-pong frame-buffer
// burst addresses so the display always reads a fully written frame.
module fb_sdram_arbiter #(
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 256,
    parameter int OFS_W       = 19,
    parameter int MAX_RD_RUN  = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ref_req,
    input  logic             rd_req,
    input  logic             wr_req,
    input  logic             wr_frame_start,
    input  logic             rd_frame_start,
    input  logic             cmd_ready,
    input  logic             cmd_done,
    output logic             cmd_valid,
    output logic [1:0]       cmd_op,
    output logic [OFS_W:0]   cmd_addr,
    output logic [8:0]       cmd_len,
    output logic             wr_gnt,
    output logic             rd_gnt,
    output logic             ref_ack,
    output logic             rd_buf
);

    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
    localparam logic [OFS_W-1:0] FRAME_OFS = OFS_W'(FRAME_WORDS);
    localparam logic [OFS_W-1:0] BURST_OFS = OFS_W'(BURST_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_RD_RUN);
    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_REF  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic               wr_buf_r, wr_buf_s;
    logic               rd_buf_next_r, rd_buf_next_s;
    logic               rd_buf_r, rd_buf_s;
    logic [OFS_W-1:0]   wr_ofs_r, wr_ofs_s;
    logic [OFS_W-1:0]   rd_ofs_r, rd_ofs_s;
    logic [RUN_W-1:0]   rd_run_r, rd_run_s;
    logic               wr_pend_r, wr_pend_s;
    logic               rd_pend_r, rd_pend_s;
    logic               cmd_valid_r, cmd_valid_s;
    logic [1:0]         cmd_op_r, cmd_op_s;
    logic [OFS_W:0]     cmd_addr_r, cmd_addr_s;
    logic [8:0]         cmd_len_r, cmd_len_s;
    logic               wr_gnt_r, wr_gnt_s;
    logic               rd_gnt_r, rd_gnt_s;
    logic               ref_ack_r, ref_ack_s;
    logic               rd_ok_s, wr_ok_s;

    // Burst length: a full burst, or whatever remains of the frame.
    function automatic logic [8:0] calc_len(input logic [OFS_W-1:0] ofs);
        logic [OFS_W-1:0] rem;
        rem = FRAME_OFS - ofs;
        if (rem > BURST_OFS) begin
            calc_len = 9'(BURST_LEN);
        end else begin
            calc_len = rem[8:0];
        end
    endfunction

    assign cmd_valid = cmd_valid_r;
    assign cmd_op    = cmd_op_r;
    assign cmd_addr  = cmd_addr_r;
    assign cmd_len   = cmd_len_r;
    assign wr_gnt    = wr_gnt_r;
    assign rd_gnt    = rd_gnt_r;
    assign ref_ack   = ref_ack_r;
    assign rd_buf    = rd_buf_r;

    // Next-state and next-register logic: frame events, arbitration, handshake.
    always_comb begin
        state_s       = state_r;
        wr_buf_s      = wr_buf_r;
        rd_buf_next_s = rd_buf_next_r;
        rd_buf_s      = rd_buf_r;
        wr_ofs_s      = wr_ofs_r;
        rd_ofs_s      = rd_ofs_r;
        rd_run_s      = rd_run_r;
        wr_pend_s     = wr_pend_r | wr_frame_start;
        rd_pend_s     = rd_pend_r | rd_frame_start;
        cmd_valid_s   = cmd_valid_r;
        cmd_op_s      = cmd_op_r;
        cmd_addr_s    = cmd_addr_r;
        cmd_len_s     = cmd_len_r;
        wr_gnt_s      = wr_gnt_r;
        rd_gnt_s      = rd_gnt_r;
        ref_ack_s     = 1'b0;
        rd_ok_s       = 1'b0;
        wr_ok_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Write-side frame event first so a simultaneous read event
                // picks up the buffer that just completed.
                if (wr_pend_s) begin
                    if (wr_ofs_r == FRAME_OFS) begin
                        rd_buf_next_s = wr_buf_r;
                        wr_buf_s      = ~wr_buf_r;
                    end else begin
                        rd_buf_next_s = rd_buf_next_r;
                        wr_buf_s      = wr_buf_r;
                    end
                    wr_ofs_s = {OFS_W{1'b0}};
                end else begin
                    wr_ofs_s = wr_ofs_r;
                end
                if (rd_pend_s) begin
                    rd_ofs_s = {OFS_W{1'b0}};
                    rd_buf_s = rd_buf_next_s;
                end else begin
                    rd_ofs_s = rd_ofs_r;
                end
                wr_pend_s = 1'b0;
                rd_pend_s = 1'b0;
                rd_ok_s = rd_req && (rd_ofs_s < FRAME_OFS);
                wr_ok_s = wr_req && (wr_ofs_s < FRAME_OFS);
                if (ref_req) begin
                    cmd_op_s    = OP_REF;
                    cmd_addr_s  = {(OFS_W+1){1'b0}};
                    cmd_len_s   = 9'd0;
                    cmd_valid_s = 1'b1;
                    state_s     = ST_ISSUE;
                end else if (wr_ok_s && (!rd_ok_s || (rd_run_r >= RUN_MAX))) begin
                    cmd_op_s    = OP_WR;
                    cmd_addr_s  = {wr_buf_s, wr_ofs_s};
                    cmd_len_s   = calc_len(wr_ofs_s);
                    wr_gnt_s    = 1'b1;
                    rd_run_s    = {RUN_W{1'b0}};
                    cmd_valid_s = 1'b1;
                    state_s     = ST_ISSUE;
                end else if (rd_ok_s) begin
                    cmd_op_s    = OP_RD;
                    cmd_addr_s  = {rd_buf_s, rd_ofs_s};
                    cmd_len_s   = calc_len(rd_ofs_s);
                    rd_gnt_s    = 1'b1;
                    cmd_valid_s = 1'b1;
                    state_s     = ST_ISSUE;
                    // Saturating keeps the >= comparison meaningful forever.
                    if (rd_run_r < RUN_MAX) begin
                        rd_run_s = rd_run_r + RUN_W'(1);
                    end else begin
                        rd_run_s = rd_run_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_s = 1'b0;
                    state_s     = ST_WAIT;
                end else begin
                    cmd_valid_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    case (cmd_op_r)
                        OP_WR:   wr_ofs_s  = wr_ofs_r + OFS_W'(cmd_len_r);
                        OP_RD:   rd_ofs_s  = rd_ofs_r + OFS_W'(cmd_len_r);
                        OP_REF:  ref_ack_s = 1'b1;
                        default: ref_ack_s = 1'b0;
                    endcase
                    wr_gnt_s = 1'b0;
                    rd_gnt_s = 1'b0;
                    cmd_op_s = OP_IDLE;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                cmd_valid_s = 1'b0;
                wr_gnt_s    = 1'b0;
                rd_gnt_s    = 1'b0;
                cmd_op_s    = OP_IDLE;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, buffer bookkeeping and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_buf_r      <= 1'b0;
            rd_buf_next_r <= 1'b1;
            rd_buf_r      <= 1'b1;
            wr_ofs_r      <= {OFS_W{1'b0}};
            rd_ofs_r      <= {OFS_W{1'b0}};
            rd_run_r      <= {RUN_W{1'b0}};
            wr_pend_r     <= 1'b0;
            rd_pend_r     <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_op_r      <= OP_IDLE;
            cmd_addr_r    <= {(OFS_W+1){1'b0}};
            cmd_len_r     <= 9'd0;
            wr_gnt_r      <= 1'b0;
            rd_gnt_r      <= 1'b0;
            ref_ack_r     <= 1'b0;
        end else begin
            wr_buf_r      <= wr_buf_s;
            rd_buf_next_r <= rd_buf_next_s;
            rd_buf_r      <= rd_buf_s;
            wr_ofs_r      <= wr_ofs_s;
            rd_ofs_r      <= rd_ofs_s;
            rd_run_r      <= rd_run_s;
            wr_pend_r     <= wr_pend_s;
            rd_pend_r     <= rd_pend_s;
            cmd_valid_r   <= cmd_valid_s;
            cmd_op_r      <= cmd_op_s;
            cmd_addr_r    <= cmd_addr_s;
            cmd_len_r     <= cmd_len_s;
            wr_gnt_r      <= wr_gnt_s;
            rd_gnt_r      <= rd_gnt_s;
            ref_ack_r     <= ref_ack_s;
        end
    end

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Directed testbench for fb_sdram_arbiter: a full-size instance and a
// 600-word-frame instance share the stimulus through a select mux.
module tb_fb_sdram_arbiter;

    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_REF = 2'b11;

    logic CLK, RSTn;
    logic ref_req, rd_req, wr_req, wr_frame_start, rd_frame_start, cmd_ready, cmd_done;
    logic sel_small;

    logic        a_cmd_valid, a_wr_gnt, a_rd_gnt, a_ref_ack, a_rd_buf;
    logic [1:0]  a_cmd_op;
    logic [19:0] a_cmd_addr;
    logic [8:0]  a_cmd_len;
    logic        s_cmd_valid, s_wr_gnt, s_rd_gnt, s_ref_ack, s_rd_buf;
    logic [1:0]  s_cmd_op;
    logic [19:0] s_cmd_addr;
    logic [8:0]  s_cmd_len;

    logic        cmd_valid, wr_gnt, rd_gnt, ref_ack, rd_buf;
    logic [1:0]  cmd_op;
    logic [19:0] cmd_addr;
    logic [8:0]  cmd_len;

    int vec_cnt = 0;
    int err_cnt = 0;

    fb_sdram_arbiter u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .ref_req(ref_req & ~sel_small), .rd_req(rd_req & ~sel_small), .wr_req(wr_req & ~sel_small),
        .wr_frame_start(wr_frame_start & ~sel_small), .rd_frame_start(rd_frame_start & ~sel_small),
        .cmd_ready(cmd_ready & ~sel_small), .cmd_done(cmd_done & ~sel_small),
        .cmd_valid(a_cmd_valid), .cmd_op(a_cmd_op), .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
        .wr_gnt(a_wr_gnt), .rd_gnt(a_rd_gnt), .ref_ack(a_ref_ack), .rd_buf(a_rd_buf)
    );

    fb_sdram_arbiter #(.FRAME_WORDS(600)) u_small (
        .CLK(CLK), .RSTn(RSTn),
        .ref_req(ref_req & sel_small), .rd_req(rd_req & sel_small), .wr_req(wr_req & sel_small),
        .wr_frame_start(wr_frame_start & sel_small), .rd_frame_start(rd_frame_start & sel_small),
        .cmd_ready(cmd_ready & sel_small), .cmd_done(cmd_done & sel_small),
        .cmd_valid(s_cmd_valid), .cmd_op(s_cmd_op), .cmd_addr(s_cmd_addr), .cmd_len(s_cmd_len),
        .wr_gnt(s_wr_gnt), .rd_gnt(s_rd_gnt), .ref_ack(s_ref_ack), .rd_buf(s_rd_buf)
    );

    assign cmd_valid = sel_small ? s_cmd_valid : a_cmd_valid;
    assign cmd_op    = sel_small ? s_cmd_op    : a_cmd_op;
    assign cmd_addr  = sel_small ? s_cmd_addr  : a_cmd_addr;
    assign cmd_len   = sel_small ? s_cmd_len   : a_cmd_len;
    assign wr_gnt    = sel_small ? s_wr_gnt    : a_wr_gnt;
    assign rd_gnt    = sel_small ? s_rd_gnt    : a_rd_gnt;
    assign ref_ack   = sel_small ? s_ref_ack   : a_ref_ack;
    assign rd_buf    = sel_small ? s_rd_buf    : a_rd_buf;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [19:0] mk_addr(input logic b, input int ofs);
        mk_addr = {b, 19'(ofs)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RSTn = 1'b0;
        ref_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0;
        step(); step();
        RSTn = 1'b1;
        step();
    endtask

    // Wait for a command, check its fields, complete the handshake, check ack/grants.
    task automatic do_cmd(input logic [1:0] eop, input logic [19:0] eaddr, input logic [8:0] elen,
                          input bit rd_pulse, input string tag);
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vec_cnt++;
        if (cmd_valid !== 1'b1) begin
            $display("FAIL %s timeout: cmd_valid=%b required 1", tag, cmd_valid);
            err_cnt++;
        end else begin
            vec_cnt++;
            if ({cmd_op, cmd_addr, cmd_len} !== {eop, eaddr, elen}) begin
                $display("FAIL %s fields: op/addr/len got %b/%h/%0d required %b/%h/%0d",
                         tag, cmd_op, cmd_addr, cmd_len, eop, eaddr, elen);
                err_cnt++;
            end
            vec_cnt++;
            if (wr_gnt !== (eop == OP_WR) || rd_gnt !== (eop == OP_RD)) begin
                $display("FAIL %s grant: wr/rd got %b/%b required %b/%b",
                         tag, wr_gnt, rd_gnt, (eop == OP_WR), (eop == OP_RD));
                err_cnt++;
            end
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            vec_cnt++;
            if (cmd_valid !== 1'b0) begin
                $display("FAIL %s accept: cmd_valid got %b required 0", tag, cmd_valid);
                err_cnt++;
            end
            if (rd_pulse) begin
                rd_frame_start = 1'b1;
                step();
                rd_frame_start = 1'b0;
            end
            cmd_done = 1'b1;
            step();
            cmd_done = 1'b0;
            vec_cnt++;
            if (ref_ack !== (eop == OP_REF) || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
                $display("FAIL %s done: ref_ack/wr/rd got %b/%b/%b required %b/0/0",
                         tag, ref_ack, wr_gnt, rd_gnt, (eop == OP_REF));
                err_cnt++;
            end
            if (eop == OP_REF) ref_req = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vec_cnt++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_len, wr_gnt, rd_gnt, ref_ack, rd_buf} !==
            {1'b0, 2'b00, 20'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL %s: v/op/addr/len/wg/rg/ack/buf got %b/%b/%h/%0d/%b/%b/%b/%b required 0/00/00000/0/0/0/0/1",
                     tag, cmd_valid, cmd_op, cmd_addr, cmd_len, wr_gnt, rd_gnt, ref_ack, rd_buf);
            err_cnt++;
        end
    endtask

    task automatic pulse_frame(input bit is_wr);
        if (is_wr) wr_frame_start = 1'b1; else rd_frame_start = 1'b1;
        step();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        sel_small = 1'b0;
        apply_reset();
        check_reset_outputs("reset_state");
        ref_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        do_cmd(OP_REF, 20'd0, 9'd0, 1'b0, "refresh_first");
        do_cmd(OP_RD, mk_addr(1'b1, 0), 9'd256, 1'b0, "read_after_refresh");
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel_small = 1'b0;
        apply_reset();
        rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cmd(OP_RD, mk_addr(1'b1, i * 256), 9'd256, 1'b0, "b2b_read");
        end
        do_cmd(OP_WR, mk_addr(1'b0, 0), 9'd256, 1'b0, "b2b_forced_write");
        do_cmd(OP_RD, mk_addr(1'b1, 1024), 9'd256, 1'b0, "b2b_read_resume");
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_frame_len();
        sel_small = 1'b1;
        apply_reset();
        wr_req = 1'b1;
        do_cmd(OP_WR, mk_addr(1'b0, 0), 9'd256, 1'b0, "small_wr0");
        do_cmd(OP_WR, mk_addr(1'b0, 256), 9'd256, 1'b0, "small_wr1");
        do_cmd(OP_WR, mk_addr(1'b0, 512), 9'd88, 1'b0, "small_wr_tail");
        for (int i = 0; i < 8; i++) begin
            step();
            vec_cnt++;
            if (cmd_valid !== 1'b0) begin
                $display("FAIL frame_full_ignore: cmd_valid got %b required 0", cmd_valid);
                err_cnt++;
            end
        end
        wr_req = 1'b0;
    endtask

    task automatic test_swap();
        sel_small = 1'b1;
        pulse_frame(1'b1);
        pulse_frame(1'b0);
        vec_cnt++;
        if (rd_buf !== 1'b0) begin
            $display("FAIL swap_rd_buf: got %b required 0", rd_buf);
            err_cnt++;
        end
        rd_req = 1'b1;
        do_cmd(OP_RD, mk_addr(1'b0, 0), 9'd256, 1'b0, "swap_read");
        rd_req = 1'b0; wr_req = 1'b1;
        do_cmd(OP_WR, mk_addr(1'b1, 0), 9'd256, 1'b0, "swap_write");
        wr_req = 1'b0;
        pulse_frame(1'b1);
        pulse_frame(1'b0);
        vec_cnt++;
        if (rd_buf !== 1'b0) begin
            $display("FAIL partial_no_swap_rd_buf: got %b required 0", rd_buf);
            err_cnt++;
        end
        wr_req = 1'b1;
        do_cmd(OP_WR, mk_addr(1'b1, 0), 9'd256, 1'b0, "partial_restart");
        wr_req = 1'b0;
    endtask

    task automatic test_rd_frame_in_wait();
        sel_small = 1'b0;
        apply_reset();
        rd_req = 1'b1;
        do_cmd(OP_RD, mk_addr(1'b1, 0), 9'd256, 1'b0, "pend_rd0");
        do_cmd(OP_RD, mk_addr(1'b1, 256), 9'd256, 1'b0, "pend_rd1");
        do_cmd(OP_RD, mk_addr(1'b1, 512), 9'd256, 1'b1, "pend_rd2_inflight");
        do_cmd(OP_RD, mk_addr(1'b1, 0), 9'd256, 1'b0, "pend_rd_restart");
        rd_req = 1'b0;
    endtask

    task automatic test_stall_async_reset();
        int n;
        sel_small = 1'b0;
        apply_reset();
        rd_req = 1'b1;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        rd_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if ({cmd_valid, cmd_op, cmd_addr, cmd_len, rd_gnt} !==
                {1'b1, OP_RD, mk_addr(1'b1, 0), 9'd256, 1'b1}) begin
                $display("FAIL stall_stable: v/op/addr/len/rg got %b/%b/%h/%0d/%b required 1/10/80000/256/1",
                         cmd_valid, cmd_op, cmd_addr, cmd_len, rd_gnt);
                err_cnt++;
            end
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("async_reset_in_wait");
        apply_reset();
    endtask

    initial begin
        sel_small = 1'b0;
        test_reset();
        test_back_to_back();
        test_frame_len();
        test_swap();
        test_rd_frame_in_wait();
        test_stall_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
